// File: rtl/state_link_pkg.sv
// Shared definitions for the state-stream link: FSM encoding, line levels, parity helper.
`timescale 1ns/1ps
package state_link_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

  // Even parity bit for a word of up to 8 bits (upper bits zero-padded)
  function automatic logic even_parity(input logic [7:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/state_word_serializer_if.sv
// Word handshake, stall control and serial/monitor outputs of the state word serializer.
`timescale 1ns/1ps
interface state_word_serializer_if #(
  parameter int WIDTH = 4
);
  import state_link_pkg::*;

  logic               stop;
  logic [WIDTH-1:0]   dataIn;
  logic               valid;
  logic               ready;
  logic               out;
  logic               busy;
  logic               frameDone;
  logic [STATE_W-1:0] stateOut;

  modport master (
    output stop, dataIn, valid,
    input  ready, out, busy, frameDone, stateOut
  );

  modport slave (
    input  stop, dataIn, valid,
    output ready, out, busy, frameDone, stateOut
  );

endinterface

// File: rtl/state_word_serializer_shift.sv
// Data shift register for the serializer: parallel load, right shift, hold otherwise.
`timescale 1ns/1ps
module serial_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             lsb,
  output logic             next_lsb
);

  logic [WIDTH-1:0] shreg_r;

  // Load has priority; neither load nor shift holds the contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_r <= '0;
    end else if (load) begin
      shreg_r <= d;
    end else if (shift) begin
      shreg_r <= shreg_r >> 1;
    end else begin
      shreg_r <= shreg_r;
    end
  end

  assign lsb = shreg_r[0];

  // Bit that becomes the LSB after the next shift
  generate
    if (WIDTH > 1) begin : g_next
      assign next_lsb = shreg_r[1];
    end else begin : g_next_one
      assign next_lsb = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/state_word_serializer.sv
// Framed serial transmitter for counter state words: start, data LSB first, [parity], stop.
// Optional parity bit enabled by defining SERIALIZER_PARITY_EN.
`timescale 1ns/1ps
module state_word_serializer
  import state_link_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int STOP_BITS = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  state_word_serializer_if.slave bus
);

  localparam logic [STATE_W-1:0] ST_IDLE   = IDLE;
  localparam logic [STATE_W-1:0] ST_START  = START;
  localparam logic [STATE_W-1:0] ST_DATA   = DATA;
  localparam logic [STATE_W-1:0] ST_STOP   = STOP;
`ifdef SERIALIZER_PARITY_EN
  localparam logic [STATE_W-1:0] ST_PARITY = PARITY;
`endif
  localparam logic [2:0] LAST_DATA = 3'(WIDTH - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  logic [STATE_W-1:0] state_r, state_s;
  logic [2:0]         bit_cnt_r, bit_cnt_s;
  logic               out_r, out_s;
  logic               last_stop_r, last_stop_s;
  logic               load_s, shift_s;
  logic               lsb_s, next_lsb_s;
`ifdef SERIALIZER_PARITY_EN
  logic               parity_r;
`endif

  serial_shift_reg #(.WIDTH(WIDTH)) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_s),
    .shift    (shift_s),
    .d        (bus.dataIn),
    .lsb      (lsb_s),
    .next_lsb (next_lsb_s)
  );

  // rst_n gating keeps ready low while reset is asserted even though state reads IDLE
  assign bus.ready     = (state_r == ST_IDLE) & ~bus.stop & rst_n;
  assign bus.busy      = (state_r != ST_IDLE);
  assign bus.out       = out_r;
  assign bus.frameDone = last_stop_r & ~bus.stop;
  assign bus.stateOut  = state_r;

  // Next-state, bit counter and next line level (out is registered for the state it enters)
  always_comb begin
    state_s   = state_r;
    bit_cnt_s = bit_cnt_r;
    out_s     = out_r;
    load_s    = 1'b0;
    shift_s   = 1'b0;
    if (state_r == ST_IDLE) begin
      if (bus.valid && bus.ready) begin
        state_s   = ST_START;
        bit_cnt_s = 3'd0;
        out_s     = START_BIT;
        load_s    = 1'b1;
      end else begin
        out_s     = LINE_IDLE;
      end
    end else if (bus.stop) begin
      state_s = state_r;
    end else begin
      case (state_r)
        ST_START: begin
          state_s   = ST_DATA;
          bit_cnt_s = 3'd0;
          out_s     = lsb_s;
        end
        ST_DATA: begin
          shift_s = 1'b1;
          if (bit_cnt_r == LAST_DATA) begin
            bit_cnt_s = 3'd0;
`ifdef SERIALIZER_PARITY_EN
            state_s   = ST_PARITY;
            out_s     = parity_r;
`else
            state_s   = ST_STOP;
            out_s     = LINE_IDLE;
`endif
          end else begin
            bit_cnt_s = bit_cnt_r + 3'd1;
            out_s     = next_lsb_s;
          end
        end
`ifdef SERIALIZER_PARITY_EN
        ST_PARITY: begin
          state_s   = ST_STOP;
          bit_cnt_s = 3'd0;
          out_s     = LINE_IDLE;
        end
`endif
        ST_STOP: begin
          out_s = LINE_IDLE;
          if (bit_cnt_r == LAST_STOP) begin
            state_s   = ST_IDLE;
            bit_cnt_s = 3'd0;
          end else begin
            bit_cnt_s = bit_cnt_r + 3'd1;
          end
        end
        default: begin
          state_s   = ST_IDLE;
          bit_cnt_s = 3'd0;
          out_s     = LINE_IDLE;
        end
      endcase
    end
    last_stop_s = (state_s == ST_STOP) && (bit_cnt_s == LAST_STOP);
  end

  // FSM, bit counter, line and last-stop-cycle registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      bit_cnt_r   <= 3'd0;
      out_r       <= LINE_IDLE;
      last_stop_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      bit_cnt_r   <= bit_cnt_s;
      out_r       <= out_s;
      last_stop_r <= last_stop_s;
    end
  end

`ifdef SERIALIZER_PARITY_EN
  // Parity of the accepted word, captured once at load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_r <= 1'b0;
    end else if (load_s) begin
      parity_r <= even_parity(8'(bus.dataIn));
    end else begin
      parity_r <= parity_r;
    end
  end
`endif

endmodule

// File: tb/tb_state_word_serializer.sv
// Self-checking bench: directed scenarios plus random words/stalls against a frame-level model.
`timescale 1ns/1ps
module tb_state_word_serializer;

  localparam int W  = 4;
  localparam int SB = 1;
`ifdef SERIALIZER_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FLEN = 1 + W + P + SB;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  state_word_serializer_if #(.WIDTH(W)) bus ();

  state_word_serializer #(.WIDTH(W), .STOP_BITS(SB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line level of frame position i for a given word
  function automatic logic ref_bit(input logic [W-1:0] word, input int i);
    if (i == 0) return 1'b0;
    if (i <= W) return word[i-1];
    if (P == 1 && i == W + 1) return ^word;
    return 1'b1;
  endfunction

  function automatic logic [2:0] ref_state(input int i);
    if (i == 0) return 3'd1;
    if (i <= W) return 3'd2;
    if (P == 1 && i == W + 1) return 3'd3;
    return 3'd4;
  endfunction

  // Send one word; frame position stall_idx is held with stop=1 for stall_len extra cycles
  task automatic send_frame(input logic [W-1:0] word, input int stall_idx,
                            input int stall_len, input string tag);
    @(negedge clk);
    bus.stop   = 1'b0;
    bus.valid  = 1'b1;
    bus.dataIn = word;
    #1 check({tag, ":ready_accept"}, 8'(bus.ready), 8'd1);
    @(negedge clk);
    bus.valid  = 1'b0;
    bus.dataIn = W'($urandom);
    for (int i = 0; i < FLEN; i++) begin
      if (i == stall_idx) begin
        for (int s = 0; s < stall_len; s++) begin
          bus.stop = 1'b1;
          #1;
          check($sformatf("%s:hold_out%0d", tag, i), 8'(bus.out), 8'(ref_bit(word, i)));
          check($sformatf("%s:hold_st%0d", tag, i), 8'(bus.stateOut), 8'(ref_state(i)));
          check($sformatf("%s:hold_fd%0d", tag, i), 8'(bus.frameDone), 8'd0);
          @(negedge clk);
        end
      end
      bus.stop = 1'b0;
      #1;
      check($sformatf("%s:out%0d", tag, i), 8'(bus.out), 8'(ref_bit(word, i)));
      check($sformatf("%s:st%0d", tag, i), 8'(bus.stateOut), 8'(ref_state(i)));
      check($sformatf("%s:busy%0d", tag, i), 8'(bus.busy), 8'd1);
      check($sformatf("%s:fd%0d", tag, i), 8'(bus.frameDone), 8'(i == FLEN - 1));
      @(negedge clk);
    end
    #1;
    check({tag, ":ready_after"}, 8'(bus.ready), 8'd1);
    check({tag, ":busy_after"}, 8'(bus.busy), 8'd0);
    check({tag, ":out_after"}, 8'(bus.out), 8'd1);
    check({tag, ":fd_after"}, 8'(bus.frameDone), 8'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.stop   = 1'b0;
    bus.valid  = 1'b0;
    bus.dataIn = '0;

    // Reset held for two cycles
    repeat (2) @(negedge clk);
    #1;
    check("rst:out", 8'(bus.out), 8'd1);
    check("rst:ready", 8'(bus.ready), 8'd0);
    check("rst:busy", 8'(bus.busy), 8'd0);
    check("rst:fd", 8'(bus.frameDone), 8'd0);
    check("rst:state", 8'(bus.stateOut), 8'd0);
    rst_n = 1'b1;
    @(negedge clk);
    #1 check("rel:ready", 8'(bus.ready), 8'd1);

    // Plain frame, then same word with DATA bit 2 held for 3 cycles
    send_frame(4'b1011, -1, 0, "plain");
    send_frame(4'b1011, 3, 3, "stall");

    // stop in IDLE blocks the accept, valid is not queued
    @(negedge clk);
    bus.stop   = 1'b1;
    bus.valid  = 1'b1;
    bus.dataIn = 4'h5;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("idle_stop:ready%0d", c), 8'(bus.ready), 8'd0);
      check($sformatf("idle_stop:busy%0d", c), 8'(bus.busy), 8'd0);
      check($sformatf("idle_stop:out%0d", c), 8'(bus.out), 8'd1);
      @(negedge clk);
    end
    send_frame(4'h5, -1, 0, "after_stop");

    // Reset during DATA bit 1 (bit 1 of 4'b1101 is 0)
    @(negedge clk);
    bus.valid  = 1'b1;
    bus.dataIn = 4'b1101;
    @(negedge clk);
    bus.valid  = 1'b0;
    repeat (2) @(negedge clk);
    #1 check("mid:bit1", 8'(bus.out), 8'd0);
    rst_n = 1'b0;
    #1;
    check("mid:out", 8'(bus.out), 8'd1);
    check("mid:state", 8'(bus.stateOut), 8'd0);
    check("mid:busy", 8'(bus.busy), 8'd0);
    check("mid:fd", 8'(bus.frameDone), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("mid:fd_rel", 8'(bus.frameDone), 8'd0);
    send_frame(4'b0110, -1, 0, "post_rst");

`ifdef SERIALIZER_PARITY_EN
    send_frame(4'b0111, -1, 0, "parity");
`endif

    // Random words with random stall position/length
    for (int n = 0; n < 20; n++) begin
      send_frame(W'($urandom), int'($urandom_range(0, FLEN - 1)),
                 int'($urandom_range(0, 3)), $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
